round_sequencer: RTL and testbench

- Game-level scheduler for the wall datapath. It sequences each round through idle, countdown, wall advance, inter-round gap and end-of-game states.
- It owns wall depth and speed: wall depth advances one step every N frames, and N shrinks each round.
- It selects the wall bit-mask index, and judges per-frame collision totals inside the goal-depth window.
- It sits between the frame-timing/collision-accumulation path and the wall bit-mask storage and renderer.

---
 rtl/round_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_round_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Round scheduler for the wall game: countdown, wall advance, inter-round gap and end states.
// Optional lives support is compiled in with `define ROUND_SEQUENCER_LIVES_EN.
module round_sequencer #(
    parameter int MAX_ROUNDS            = 5,
    parameter int NUM_WALLS             = 10,
    parameter int COUNTDOWN_FRAMES      = 90,
    parameter int GAP_FRAMES            = 60,
    parameter int START_FRAMES_PER_TICK = 11,
    parameter int MIN_FRAMES_PER_TICK   = 3,
    parameter int GOAL_DEPTH            = 60,
    parameter int GOAL_DEPTH_DELTA      = 10,
    parameter int MAX_WALL_DEPTH        = 75,
    parameter int COLLISION_THRESHOLD   = 65536
`ifdef ROUND_SEQUENCER_LIVES_EN
    , parameter int NUM_LIVES           = 3
`endif
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_game_in,
    input  logic [1:0]  num_players_in,
    input  logic        new_frame_in,
    input  logic [20:0] frame_collisions_in,
    input  logic        frame_collisions_valid_in,
    output logic [3:0]  wall_idx_out,
    output logic [7:0]  wall_depth_out,
    output logic        wall_active_out,
    output logic [7:0]  round_out,
    output logic [7:0]  frames_per_tick_out,
    output logic [2:0]  game_state_out
`ifdef ROUND_SEQUENCER_LIVES_EN
    , output logic [1:0] lives_out
`endif
);

    typedef enum logic [2:0] {
        LOST      = 3'd0,
        IDLE      = 3'd1,
        WON       = 3'd2,
        COUNTDOWN = 3'd3,
        ADVANCE   = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  depth_q, depth_d;
    logic [7:0]  round_q, round_d;
    logic [7:0]  fpt_q, fpt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic [3:0]  first_idx;
    logic        in_window;
    logic        fail;
    logic        finish;
    logic        lose;
`ifdef ROUND_SEQUENCER_LIVES_EN
    logic [1:0]  lives_q, lives_d;
    logic        hit_q, hit_d;
`endif

    always_comb begin
        case (num_players_in)
            2'd0:    first_idx = 4'(0 % NUM_WALLS);
            2'd1:    first_idx = 4'(3 % NUM_WALLS);
            2'd2:    first_idx = 4'(6 % NUM_WALLS);
            default: first_idx = 4'(7 % NUM_WALLS);
        endcase
    end

    assign in_window = (int'(depth_q) >= GOAL_DEPTH - GOAL_DEPTH_DELTA) &&
                       (int'(depth_q) <= GOAL_DEPTH + GOAL_DEPTH_DELTA);
    assign fail = frame_collisions_valid_in && in_window &&
                  (frame_collisions_in >= 21'(COLLISION_THRESHOLD));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        depth_d = depth_q;
        round_d = round_q;
        fpt_d   = fpt_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        lose    = 1'b0;
`ifdef ROUND_SEQUENCER_LIVES_EN
        lives_d = lives_q;
        hit_d   = hit_q;
`endif
        case (state_q)
            IDLE, WON, LOST: begin
                if (start_game_in) begin
                    state_d = COUNTDOWN;
                    idx_d   = first_idx;
                    depth_d = 8'd0;
                    round_d = 8'd0;
                    fpt_d   = 8'(START_FRAMES_PER_TICK);
                    cnt_d   = 8'd0;
`ifdef ROUND_SEQUENCER_LIVES_EN
                    lives_d = 2'(NUM_LIVES);
                    hit_d   = 1'b0;
`endif
                end
            end
            COUNTDOWN: begin
                if (new_frame_in) begin
                    if (cnt_q == 8'(COUNTDOWN_FRAMES - 1)) begin
                        state_d = ADVANCE;
                        cnt_d   = 8'd0;
                        depth_d = 8'd0;
`ifdef ROUND_SEQUENCER_LIVES_EN
                        hit_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ADVANCE: begin
                if (new_frame_in) begin
                    if (cnt_q == fpt_q - 8'd1) begin
                        cnt_d = 8'd0;
                        if (depth_q == 8'(MAX_WALL_DEPTH - 1)) finish = 1'b1;
                        else depth_d = depth_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`ifdef ROUND_SEQUENCER_LIVES_EN
                if (fail && !hit_q) begin
                    hit_d   = 1'b1;
                    lives_d = lives_q - 2'd1;
                    lose    = (lives_q == 2'd1);
                end
`else
                lose = fail;
`endif
                // A losing judgement outranks a finishing tick in the same cycle.
                if (lose) begin
                    state_d = LOST;
                    depth_d = depth_q;
                    cnt_d   = cnt_q;
                end else if (finish) begin
                    round_d = round_q + 8'd1;
                    if (round_q + 8'd1 == 8'(MAX_ROUNDS)) begin
                        state_d = WON;
                    end else begin
                        state_d = GAP;
                        depth_d = 8'd0;
                        idx_d   = (idx_q == 4'(NUM_WALLS - 1)) ? 4'd0 : idx_q + 4'd1;
                        fpt_d   = (fpt_q > 8'(MIN_FRAMES_PER_TICK)) ? fpt_q - 8'd1
                                                                   : 8'(MIN_FRAMES_PER_TICK);
                    end
                end
            end
            GAP: begin
                depth_d = 8'd0;
                if (new_frame_in) begin
                    if (cnt_q == 8'(GAP_FRAMES - 1)) begin
                        state_d = COUNTDOWN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d == ADVANCE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            depth_q  <= 8'd0;
            round_q  <= 8'd0;
            fpt_q    <= 8'(START_FRAMES_PER_TICK);
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
`ifdef ROUND_SEQUENCER_LIVES_EN
            lives_q  <= 2'(NUM_LIVES);
            hit_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            depth_q  <= depth_d;
            round_q  <= round_d;
            fpt_q    <= fpt_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
`ifdef ROUND_SEQUENCER_LIVES_EN
            lives_q  <= lives_d;
            hit_q    <= hit_d;
`endif
        end
    end

    assign game_state_out      = state_q;
    assign wall_idx_out        = idx_q;
    assign wall_depth_out      = depth_q;
    assign wall_active_out     = active_q;
    assign round_out           = round_q;
    assign frames_per_tick_out = fpt_q;
`ifdef ROUND_SEQUENCER_LIVES_EN
    assign lives_out           = lives_q;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: expected snapshots are queued as stimulus is driven
// and compared one cycle later. A second instance uses a wider judging window.
module tb_round_sequencer;

    localparam logic [2:0] S_LOST = 3'd0, S_IDLE = 3'd1, S_WON = 3'd2,
                           S_CD = 3'd3, S_ADV = 3'd4, S_GAP = 3'd5;

    logic        clk = 1'b0;
    logic        rst, start, new_frame, coll_valid;
    logic [1:0]  num_players;
    logic [20:0] coll;
    logic [3:0]  wall_idx, wall_idx_w;
    logic [7:0]  wall_depth, wall_depth_w, round_cnt, round_cnt_w, fpt, fpt_w;
    logic        active, active_w;
    logic [2:0]  game_state, game_state_w;
`ifdef ROUND_SEQUENCER_LIVES_EN
    logic [1:0]  lives, lives_w;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] sb_w[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    round_sequencer #(
        .MAX_ROUNDS(2), .NUM_WALLS(10), .COUNTDOWN_FRAMES(2), .GAP_FRAMES(2),
        .START_FRAMES_PER_TICK(3), .MIN_FRAMES_PER_TICK(2), .GOAL_DEPTH(5),
        .GOAL_DEPTH_DELTA(1), .MAX_WALL_DEPTH(8), .COLLISION_THRESHOLD(100)
`ifdef ROUND_SEQUENCER_LIVES_EN
        , .NUM_LIVES(2)
`endif
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_game_in(start), .num_players_in(num_players),
        .new_frame_in(new_frame), .frame_collisions_in(coll),
        .frame_collisions_valid_in(coll_valid), .wall_idx_out(wall_idx),
        .wall_depth_out(wall_depth), .wall_active_out(active), .round_out(round_cnt),
        .frames_per_tick_out(fpt), .game_state_out(game_state)
`ifdef ROUND_SEQUENCER_LIVES_EN
        , .lives_out(lives)
`endif
    );

    round_sequencer #(
        .MAX_ROUNDS(2), .NUM_WALLS(10), .COUNTDOWN_FRAMES(2), .GAP_FRAMES(2),
        .START_FRAMES_PER_TICK(3), .MIN_FRAMES_PER_TICK(2), .GOAL_DEPTH(5),
        .GOAL_DEPTH_DELTA(2), .MAX_WALL_DEPTH(8), .COLLISION_THRESHOLD(100)
`ifdef ROUND_SEQUENCER_LIVES_EN
        , .NUM_LIVES(2)
`endif
    ) dut_w (
        .clk_in(clk), .rst_in(rst), .start_game_in(start), .num_players_in(num_players),
        .new_frame_in(new_frame), .frame_collisions_in(coll),
        .frame_collisions_valid_in(coll_valid), .wall_idx_out(wall_idx_w),
        .wall_depth_out(wall_depth_w), .wall_active_out(active_w), .round_out(round_cnt_w),
        .frames_per_tick_out(fpt_w), .game_state_out(game_state_w)
`ifdef ROUND_SEQUENCER_LIVES_EN
        , .lives_out(lives_w)
`endif
    );

    function automatic logic [31:0] mk(input logic [2:0] s, input logic [3:0] i,
                                       input logic [7:0] d, input logic [7:0] r,
                                       input logic [7:0] f, input logic a);
        return {s, i, d, r, f, a};
    endfunction

    function automatic logic [31:0] obs_main();
        return {game_state, wall_idx, wall_depth, round_cnt, fpt, active};
    endfunction

    function automatic logic [31:0] obs_wide();
        return {game_state_w, wall_idx_w, wall_depth_w, round_cnt_w, fpt_w, active_w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic cv, input logic [20:0] cval);
        new_frame = 1'b1; coll_valid = cv; coll = cval;
        step();
        new_frame = 1'b0; coll_valid = 1'b0; coll = 21'd0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 21'd0);
    endtask

    task automatic coll_pulse(input logic [20:0] cval);
        coll_valid = 1'b1; coll = cval;
        step();
        coll_valid = 1'b0; coll = 21'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic to_advance(input logic [1:0] np);
        do_reset();
        num_players = np; start = 1'b1;
        step();
        start = 1'b0;
        frames(2);
    endtask

    task automatic test_reset();
        logic [3:0] idx_tab [4];
        idx_tab[0] = 4'd0; idx_tab[1] = 4'd3; idx_tab[2] = 4'd6; idx_tab[3] = 4'd7;
        rst = 1'b1; start = 1'b1;
        sb.push_back(mk(S_IDLE, 4'd0, 8'd0, 8'd0, 8'd3, 1'b0));
        step();
        rst = 1'b0; start = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL reset got=%h exp=%h", obs_main(), e);
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(S_IDLE, 4'd0, 8'd0, 8'd0, 8'd3, 1'b0));
            frame(1'b1, 21'd200);
            e = sb.pop_front(); checks++;
            if (obs_main() !== e) begin
                errors++; $display("FAIL idle_hold got=%h exp=%h", obs_main(), e);
            end
        end
        for (int np = 0; np < 4; np++) begin
            do_reset();
            num_players = 2'(np); start = 1'b1;
            sb.push_back(mk(S_CD, idx_tab[np], 8'd0, 8'd0, 8'd3, 1'b0));
            step();
            start = 1'b0;
            e = sb.pop_front(); checks++;
            if (obs_main() !== e) begin
                errors++; $display("FAIL start_np%0d got=%h exp=%h", np, obs_main(), e);
            end
        end
    endtask

    task automatic test_clean_run();
        logic [7:0] f_tick;
        logic [3:0] idx;
        do_reset();
        num_players = 2'd2; start = 1'b1;
        sb.push_back(mk(S_CD, 4'd6, 8'd0, 8'd0, 8'd3, 1'b0));
        step();
        start = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL start got=%h exp=%h", obs_main(), e);
        end
        for (int r = 0; r < 2; r++) begin
            f_tick = 8'(3 - r);
            idx = 4'(6 + r);
            sb.push_back(mk(S_CD, idx, 8'd0, 8'(r), f_tick, 1'b0));
            sb.push_back(mk(S_ADV, idx, 8'd0, 8'(r), f_tick, 1'b1));
            for (int c = 0; c < 2; c++) begin
                frame(1'b0, 21'd0);
                e = sb.pop_front(); checks++;
                if (obs_main() !== e) begin
                    errors++; $display("FAIL countdown r=%0d f=%0d got=%h exp=%h", r, c, obs_main(), e);
                end
            end
            for (int d = 0; d < 8; d++) begin
                for (int f = 1; f <= int'(f_tick); f++) begin
                    if (f < int'(f_tick))  sb.push_back(mk(S_ADV, idx, 8'(d), 8'(r), f_tick, 1'b1));
                    else if (d < 7)        sb.push_back(mk(S_ADV, idx, 8'(d + 1), 8'(r), f_tick, 1'b1));
                    else if (r == 0)       sb.push_back(mk(S_GAP, 4'd7, 8'd0, 8'd1, 8'd2, 1'b0));
                    else                   sb.push_back(mk(S_WON, 4'd7, 8'd7, 8'd2, 8'd2, 1'b0));
                    frame(1'b0, 21'd0);
                    e = sb.pop_front(); checks++;
                    if (obs_main() !== e) begin
                        errors++; $display("FAIL clean_run r=%0d d=%0d f=%0d got=%h exp=%h", r, d, f, obs_main(), e);
                    end
                end
            end
            if (r == 0) begin
                sb.push_back(mk(S_GAP, 4'd7, 8'd0, 8'd1, 8'd2, 1'b0));
                sb.push_back(mk(S_CD, 4'd7, 8'd0, 8'd1, 8'd2, 1'b0));
                for (int g = 0; g < 2; g++) begin
                    frame(1'b0, 21'd0);
                    e = sb.pop_front(); checks++;
                    if (obs_main() !== e) begin
                        errors++; $display("FAIL gap g=%0d got=%h exp=%h", g, obs_main(), e);
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(S_WON, 4'd7, 8'd7, 8'd2, 8'd2, 1'b0));
            frame(1'b1, 21'd500);
            e = sb.pop_front(); checks++;
            if (obs_main() !== e) begin
                errors++; $display("FAIL won_hold got=%h exp=%h", obs_main(), e);
            end
        end
    endtask

`ifndef ROUND_SEQUENCER_LIVES_EN
    task automatic test_collision();
        to_advance(2'd2);
        frames(9);
        sb.push_back(mk(S_ADV, 4'd6, 8'd3, 8'd0, 8'd3, 1'b1));
        coll_pulse(21'd100);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL coll_below_window got=%h exp=%h", obs_main(), e);
        end
        frames(6);
        sb.push_back(mk(S_ADV, 4'd6, 8'd5, 8'd0, 8'd3, 1'b1));
        coll_pulse(21'd99);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL coll_under_threshold got=%h exp=%h", obs_main(), e);
        end
        sb.push_back(mk(S_LOST, 4'd6, 8'd5, 8'd0, 8'd3, 1'b0));
        coll_pulse(21'd100);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL coll_lost got=%h exp=%h", obs_main(), e);
        end
        sb.push_back(mk(S_LOST, 4'd6, 8'd5, 8'd0, 8'd3, 1'b0));
        frame(1'b0, 21'd0);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL lost_hold got=%h exp=%h", obs_main(), e);
        end
        to_advance(2'd2);
        frames(12);
        sb.push_back(mk(S_LOST, 4'd6, 8'd4, 8'd0, 8'd3, 1'b0));
        coll_pulse(21'd100);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL coll_window_low_edge got=%h exp=%h", obs_main(), e);
        end
        to_advance(2'd2);
        frames(21);
        sb.push_back(mk(S_ADV, 4'd6, 8'd7, 8'd0, 8'd3, 1'b1));
        coll_pulse(21'd100);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL coll_above_window got=%h exp=%h", obs_main(), e);
        end
    endtask

    task automatic test_simultaneous();
        to_advance(2'd0);
        frames(23);
        sb.push_back(mk(S_GAP, 4'd1, 8'd0, 8'd1, 8'd2, 1'b0));
        sb_w.push_back(mk(S_LOST, 4'd0, 8'd7, 8'd0, 8'd3, 1'b0));
        frame(1'b1, 21'd100);
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL finish_outside_window got=%h exp=%h", obs_main(), e);
        end
        e = sb_w.pop_front(); checks++;
        if (obs_wide() !== e) begin
            errors++; $display("FAIL finish_and_fail got=%h exp=%h", obs_wide(), e);
        end
    endtask
`endif

    task automatic test_reset_mid();
        to_advance(2'd1);
        frames(12);
        start = 1'b1; num_players = 2'd3;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(S_ADV, 4'd3, 8'd4, 8'd0, 8'd3, 1'b1));
            frame(1'b0, 21'd0);
            e = sb.pop_front(); checks++;
            if (obs_main() !== e) begin
                errors++; $display("FAIL start_ignored got=%h exp=%h", obs_main(), e);
            end
        end
        rst = 1'b1;
        sb.push_back(mk(S_IDLE, 4'd0, 8'd0, 8'd0, 8'd3, 1'b0));
        frame(1'b0, 21'd0);
        rst = 1'b0; start = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL reset_mid got=%h exp=%h", obs_main(), e);
        end
        sb.push_back(mk(S_IDLE, 4'd0, 8'd0, 8'd0, 8'd3, 1'b0));
        step();
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL idle_after_reset got=%h exp=%h", obs_main(), e);
        end
    endtask

`ifdef ROUND_SEQUENCER_LIVES_EN
    task automatic test_lives();
        logic [4:0] lv;
        to_advance(2'd2);
        sb.push_back({2'd2, S_ADV});
        lv = {lives, game_state};
        e = sb.pop_front(); checks++;
        if (lv !== e[4:0]) begin
            errors++; $display("FAIL lives_start got=%h exp=%h", lv, e[4:0]);
        end
        frames(15);
        for (int i = 0; i < 2; i++) begin
            sb.push_back({2'd1, S_ADV});
            coll_pulse(21'd100);
            lv = {lives, game_state};
            e = sb.pop_front(); checks++;
            if (lv !== e[4:0]) begin
                errors++; $display("FAIL lives_hit%0d got=%h exp=%h", i, lv, e[4:0]);
            end
        end
        frames(9);
        sb.push_back(mk(S_GAP, 4'd7, 8'd0, 8'd1, 8'd2, 1'b0));
        e = sb.pop_front(); checks++;
        if (obs_main() !== e) begin
            errors++; $display("FAIL lives_round_done got=%h exp=%h", obs_main(), e);
        end
        frames(4);
        frames(10);
        sb.push_back({2'd0, S_LOST});
        coll_pulse(21'd100);
        lv = {lives, game_state};
        e = sb.pop_front(); checks++;
        if (lv !== e[4:0]) begin
            errors++; $display("FAIL lives_last got=%h exp=%h", lv, e[4:0]);
        end
        start = 1'b1;
        sb.push_back({2'd2, S_CD});
        step();
        start = 1'b0;
        lv = {lives, game_state};
        e = sb.pop_front(); checks++;
        if (lv !== e[4:0]) begin
            errors++; $display("FAIL lives_reload got=%h exp=%h", lv, e[4:0]);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; new_frame = 1'b0; coll_valid = 1'b0;
        coll = 21'd0; num_players = 2'd0;
        test_reset();
        test_clean_run();
`ifndef ROUND_SEQUENCER_LIVES_EN
        test_collision();
        test_simultaneous();
`endif
        test_reset_mid();
`ifdef ROUND_SEQUENCER_LIVES_EN
        test_lives();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
